// File: rtl/wb_sig_responder_pkg.sv
// Shared definitions for the Wishbone signature responder: register map,
// FSM encoding, STATUS bit positions and a byte-lane merge helper.
package wb_sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] OFF_SIG    = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_SCR0   = 8'h0C;
  localparam logic [7:0] OFF_SCR1   = 8'h10;
  localparam logic [7:0] OFF_WRCNT  = 8'h14;

  localparam int STATUS_STARTED = 0;
  localparam int STATUS_PASSED  = 1;
  localparam int STATUS_FAULT   = 2;
  localparam int CTRL_CLEAR     = 0;

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_sig_responder_if.sv
// Wishbone classic bus bundle between the wb_host initiator and the
// signature responder target.
interface wb_sig_responder_if #(parameter int AW = 8);
  // Handshake: the master raises cyc and stb and holds request fields stable
  // until it sees ack or err (each high for exactly one cycle); dropping cyc
  // or stb before that abandons the request with no side effect.
  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic          wbs_we_i;
  logic [AW-1:0] wbs_adr_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_i;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o;
  logic          wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_sig_responder_monitor.sv
// Start/pass sequence monitor: sticky flags driven by each committed
// signature write, cleared by a CTRL write or reset.
module wb_sig_monitor #(
  parameter logic [15:0] SIG_START = 16'hAB60,
  parameter logic [15:0] SIG_PASS  = 16'hAB6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_we,
  input  logic [15:0] sig_new,
  input  logic        clear,
  output logic        started,
  output logic        passed,
  output logic        fault
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      started <= 1'b0;
      passed  <= 1'b0;
      fault   <= 1'b0;
    end else if (sig_we) begin
      if (sig_new == SIG_START) begin
        started <= 1'b1;
      end
      // Order check uses the start flag as it stood before this write.
      if (sig_new == SIG_PASS) begin
        if (started) begin
          passed <= 1'b1;
        end else begin
          fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_sig_responder.sv
// Wishbone classic target holding the firmware progress signature, scratch
// registers and a write counter, with a start/pass sequence monitor.
module wb_sig_responder
  import wb_sig_pkg::*;
#(
  parameter int          AW        = 8,
  parameter int          WAIT_CYC  = 1,
  parameter logic [15:0] SIG_START = 16'hAB60,
  parameter logic [15:0] SIG_PASS  = 16'hAB6A
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_sig_responder_if.slave     bus,
  output logic [15:0]           sig_o,
  output logic                  started_o,
  output logic                  passed_o,
  output logic                  fault_o,
  output state_t                dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req, resp, mapped, ack, err, wr;
  logic        hit_sig, hit_ctrl, hit_status, hit_scr0, hit_scr1, hit_wrcnt;
  logic [31:0] off, rdat;
  logic [15:0] sig_q, sig_new, wrcnt_q;
  logic [31:0] scr0_q, scr1_q;
  logic        sig_we, clear;

  assign req = bus.wbs_cyc_i & bus.wbs_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is loaded with WAIT_CYC and RESP follows the WAIT cycle in
  // which it reaches zero, giving stb->ack = WAIT_CYC+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // Word-aligned offset; adr[1:0] is masked off.
  assign off        = 32'(bus.wbs_adr_i) & ~32'h3;
  assign hit_sig    = (off == 32'(OFF_SIG));
  assign hit_ctrl   = (off == 32'(OFF_CTRL));
  assign hit_status = (off == 32'(OFF_STATUS));
  assign hit_scr0   = (off == 32'(OFF_SCR0));
  assign hit_scr1   = (off == 32'(OFF_SCR1));
  assign hit_wrcnt  = (off == 32'(OFF_WRCNT));
  assign mapped     = hit_sig | hit_ctrl | hit_status | hit_scr0 | hit_scr1 | hit_wrcnt;

  // A reset arriving in RESP suppresses the response that cycle.
  assign resp = (state_q == ST_RESP) & req & ~wb_rst_i;
  assign ack  = resp & mapped;
  assign err  = resp & ~mapped;
  assign wr   = ack & bus.wbs_we_i;

  assign sig_new = {bus.wbs_sel_i[1] ? bus.wbs_dat_i[15:8] : sig_q[15:8],
                    bus.wbs_sel_i[0] ? bus.wbs_dat_i[7:0]  : sig_q[7:0]};
  assign sig_we  = wr & hit_sig;
  assign clear   = wr & hit_ctrl & bus.wbs_sel_i[0] & bus.wbs_dat_i[CTRL_CLEAR];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sig_q   <= 16'h0;
      scr0_q  <= 32'h0;
      scr1_q  <= 32'h0;
      wrcnt_q <= 16'h0;
    end else if (wr) begin
      if (hit_sig) begin
        sig_q <= sig_new;
      end
      if (hit_scr0) begin
        scr0_q <= lane_merge(scr0_q, bus.wbs_dat_i, bus.wbs_sel_i);
      end
      if (hit_scr1) begin
        scr1_q <= lane_merge(scr1_q, bus.wbs_dat_i, bus.wbs_sel_i);
      end
      if (wrcnt_q != 16'hFFFF) begin
        wrcnt_q <= wrcnt_q + 16'd1;
      end
    end
  end

  wb_sig_monitor #(
    .SIG_START (SIG_START),
    .SIG_PASS  (SIG_PASS)
  ) u_monitor (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .sig_we  (sig_we),
    .sig_new (sig_new),
    .clear   (clear),
    .started (started_o),
    .passed  (passed_o),
    .fault   (fault_o)
  );

  always_comb begin
    rdat = 32'h0;
    if (hit_sig) begin
      rdat = {16'h0, sig_q};
    end else if (hit_status) begin
      rdat[STATUS_STARTED] = started_o;
      rdat[STATUS_PASSED]  = passed_o;
      rdat[STATUS_FAULT]   = fault_o;
    end else if (hit_scr0) begin
      rdat = scr0_q;
    end else if (hit_scr1) begin
      rdat = scr1_q;
    end else if (hit_wrcnt) begin
      rdat = {16'h0, wrcnt_q};
    end
  end

  assign bus.wbs_dat_o = (ack & ~bus.wbs_we_i) ? rdat : 32'h0;
  assign bus.wbs_ack_o = ack;
  assign bus.wbs_err_o = err;
  assign sig_o         = sig_q;

endmodule

// File: tb/tb_wb_sig_responder.sv
// Bench for wb_sig_responder: register vectors from a table, scoreboarded
// responses, plus abort, back-to-back and reset-in-wait sequences.
module tb_wb_sig_responder;
  import wb_sig_pkg::*;

  localparam int AW = 8;
  localparam int W  = 34;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_rdat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sig_responder_if #(.AW(AW)) bus ();
  logic [15:0] sig;
  logic        started, passed, fault;
  state_t      dbg_state;

  wb_sig_responder #(
    .AW(AW), .WAIT_CYC(1), .SIG_START(16'hAB60), .SIG_PASS(16'hAB6A)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .sig_o     (sig),
    .started_o (started),
    .passed_o  (passed),
    .fault_o   (fault),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic drive_req(input logic we, input logic [7:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = dat;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_bus();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_vec(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic exp_err, input logic [31:0] exp_rdat);
    vec_t v;
    v.we = we; v.adr = adr; v.sel = sel; v.dat = dat;
    v.exp_err = exp_err; v.exp_rdat = exp_rdat;
    vecs.push_back(v);
  endtask

  // One request, held until ack/err or a 20-cycle budget runs out.
  task automatic bus_cycle(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic ack, output logic err,
                           output logic [31:0] rdat, output int lat);
    ack = 1'b0; err = 1'b0; rdat = 32'h0; lat = -1;
    @(posedge clk); #1;
    drive_req(we, adr, sel, dat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbs_err_o) begin
        ack = bus.wbs_ack_o; err = bus.wbs_err_o; rdat = bus.wbs_dat_o; lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic ack, err;
    logic [31:0] rdat;
    logic [W-1:0] exp;
    int lat;
    v = vecs[idx];
    exp_q.push_back({~v.exp_err, v.exp_err, v.we ? 32'h0 : v.exp_rdat});
    bus_cycle(v.we, v.adr, v.sel, v.dat, ack, err, rdat, lat);
    exp = exp_q.pop_front();
    check($sformatf("vec%0d_resp", idx), 64'({ack, err, v.we ? 32'h0 : rdat}), 64'(exp));
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, dbl, seen;
    logic prev;
    logic [W-1:0] exp;

    idle_bus();
    // 0: reset STATUS read
    add_vec(0, 8'h08, 4'hF, 32'h0, 0, 32'h0);
    // 1-5: start then pass
    add_vec(1, 8'h00, 4'hF, 32'h0000AB60, 0, 32'h0);
    add_vec(1, 8'h00, 4'hF, 32'h0000AB6A, 0, 32'h0);
    add_vec(0, 8'h08, 4'hF, 32'h0, 0, 32'h3);
    add_vec(0, 8'h14, 4'hF, 32'h0, 0, 32'h2);
    add_vec(0, 8'h00, 4'hF, 32'h0, 0, 32'h0000AB6A);
    // 6-9: pass before start, then clear
    add_vec(1, 8'h00, 4'hF, 32'h0000AB6A, 0, 32'h0);
    add_vec(0, 8'h08, 4'hF, 32'h0, 0, 32'h4);
    add_vec(1, 8'h04, 4'hF, 32'h1, 0, 32'h0);
    add_vec(0, 8'h08, 4'hF, 32'h0, 0, 32'h0);
    // 10-25: byte lanes, RO writes, unmapped offsets
    add_vec(1, 8'h0C, 4'b0101, 32'h11223344, 0, 32'h0);
    add_vec(0, 8'h0C, 4'hF, 32'h0, 0, 32'h00220044);
    add_vec(1, 8'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    add_vec(0, 8'h10, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    add_vec(1, 8'h08, 4'hF, 32'hFFFFFFFF, 0, 32'h0);
    add_vec(0, 8'h08, 4'hF, 32'h0, 0, 32'h0);
    add_vec(1, 8'h00, 4'b0001, 32'hFFFF1234, 0, 32'h0);
    add_vec(0, 8'h00, 4'hF, 32'h0, 0, 32'h00000034);
    add_vec(1, 8'h00, 4'b1100, 32'hAB00AB60, 0, 32'h0);
    add_vec(0, 8'h00, 4'hF, 32'h0, 0, 32'h00000034);
    add_vec(0, 8'h04, 4'hF, 32'h0, 0, 32'h0);
    add_vec(0, 8'h14, 4'hF, 32'h0, 0, 32'h5);
    add_vec(0, 8'h20, 4'hF, 32'h0, 1, 32'h0);
    add_vec(1, 8'h18, 4'hF, 32'h55, 1, 32'h0);
    add_vec(0, 8'h14, 4'hF, 32'h0, 0, 32'h5);
    add_vec(0, 8'h03, 4'hF, 32'h0, 0, 32'h00000034);
    // 26-27: after aborted SCR1 write
    add_vec(0, 8'h10, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    add_vec(0, 8'h14, 4'hF, 32'h0, 0, 32'h5);

    // Reset state
    do_reset(5);
    @(negedge clk);
    check("rst_outputs", 64'({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, sig, started, passed, fault}), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    run_range(0, 0);

    run_range(1, 5);
    check("pass_flags", 64'({sig, started, passed, fault}), 64'({16'hAB6A, 3'b110}));

    do_reset(2);
    run_range(6, 6);
    check("fault_flags", 64'({started, passed, fault}), 64'b001);
    run_range(7, 9);
    check("clear_flags", 64'({started, passed, fault}), 64'b000);

    do_reset(2);
    run_range(10, 25);

    // Abort a SCR1 write while it sits in WAIT
    @(posedge clk); #1;
    drive_req(1'b1, 8'h10, 4'hF, 32'h12345678);
    @(posedge clk); #1;
    check("abort_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    idle_bus();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbs_err_o) seen++;
    end
    check("abort_no_ack", 64'(seen), 64'd0);
    run_range(26, 27);

    // Three reads with stb held continuously
    @(posedge clk); #1;
    drive_req(1'b0, 8'h00, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) exp_q.push_back({2'b10, 32'h00000034});
    acks = 0; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        if (prev) dbl++;
        acks++;
        exp = exp_q.pop_front();
        check($sformatf("b2b_read%0d", acks), 64'({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o}), 64'(exp));
      end
      prev = bus.wbs_ack_o;
    end
    @(posedge clk); #1;
    idle_bus();
    repeat (4) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
    end
    check("b2b_ack_count", 64'(acks), 64'd3);
    check("b2b_double_ack", 64'(dbl), 64'd0);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset arriving while a read waits
    @(posedge clk); #1;
    drive_req(1'b0, 8'h00, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbs_err_o) seen++;
    end
    check("rst_wait_no_ack", 64'(seen), 64'd0);
    check("rst_wait_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_wait_sig", 64'(sig), 64'h0);
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
